alu_wb_stage: RTL and testbench
===============================

// Module: alu_wb_stage
// PURPOSE
//  Writeback/flag-commit stage directly downstream of the ALU. Accepts ALU result+APSR flags with valid/ready,
//  buffers them in a 2-entry skid buffer toward the register-file write port, and owns the PSR register whose
//  value is fed back to the ALU psr input. Full throughput (1 op/cycle), registered ready, no combinational in->out path.
// PARAMETERS
//  DW        `DATA_WIDTH   result width
//  PSRW      `PSR_WIDTH    PSR register width
//  APSRW     `APSR_WIDTH   arithmetic flag width; field PSR[`APSR_MAX:`APSR_MIN]
//  RAW       3             destination register address width
// PORTS
//  clk         in   1      clock, rising edge
//  rst         in   1      synchronous reset, active-high
//  flush       in   1      drop all buffered ops (branch/exception)
//  in_valid    in   1      ALU op presented
//  in_ready    out  1      stage can accept (registered)
//  in_result   in   DW     ALU result
//  in_apsr     in   APSRW  ALU flags {carry,zero,neg} per `APSR_* indices
//  in_rd       in   RAW    destination register
//  in_wr_en    in   1      op writes register file
//  in_flags_en in   1      op commits flags to PSR
//  out_valid   out  1      writeback entry valid
//  out_ready   in   1      register file accepts writeback
//  out_result  out  DW     writeback data
//  out_rd      out  RAW    writeback address
//  out_wr_en   out  1      writeback enable qualifier
//  psr_we      in   1      software write of full PSR
//  psr_wdata   in   PSRW   software PSR data
//  psr         out  PSRW   current PSR, to ALU psr input
// BEHAVIOUR
//  Reset (rst=1 at edge): out_valid=0, in_ready=1, psr=0, out_result/out_rd/out_wr_en=0, both entries invalid.
//  Transfers: accept = in_valid & in_ready & ~flush; retire = out_valid & out_ready.
//  Storage: MAIN entry drives out_*; SKID entry catches one op when MAIN is stalled.
//  FSM (state = occupancy):
//   EMPTY: accept -> MAIN<=in, ONE.
//   ONE:   accept&retire -> MAIN<=in, ONE; accept&~retire -> SKID<=in, FULL; ~accept&retire -> EMPTY.
//   FULL:  in_ready=0; retire -> MAIN<=SKID, ONE; else hold.
//   in_ready registered = (next state != FULL).
//  Latency: accepted op visible on out_* the next cycle; out_* stable while out_valid & ~out_ready.
//  out_valid=1 with out_wr_en=0 is legal (flag-only op); it must still retire through the handshake.
//  flush: next cycle EMPTY, out_valid=0, in_ready=1; input offered same cycle is dropped; PSR not touched.
//  PSR update at the accept edge (not at retire), so the next ALU op sees new flags:
//   accept&in_flags_en -> psr[`APSR_MAX:`APSR_MIN] <= in_apsr.
//   psr_we -> psr <= psr_wdata.
//   Both same cycle -> non-APSR bits from psr_wdata, APSR bits from in_apsr (flag commit wins).
//   flush same cycle as accept: no accept, so flags are not committed; psr_we still applies.
//  rst overrides flush, psr_we and all handshakes; reset mid-stall discards MAIN and SKID.
//  No X on outputs after reset; out_result/out_rd/out_wr_en hold last value when out_valid=0.
// TESTING
//  1 Reset: rst=1 2 cycles with in_valid=1 -> out_valid=0, in_ready=1, psr=0 after release.
//  2 Stream: 8 ops result=0x01..0x08, out_ready=1 -> outputs 1 cycle later in order, in_ready stays 1.
//  3 Backpressure: out_ready=0, send 0x11,0x22,0x33 -> 0x11 on out, 0x22 in SKID, in_ready=0, 0x33 held;
//    out_ready=1 -> 0x11,0x22,0x33 retire in order, nothing lost or duplicated.
//  4 Flags: accept in_apsr with carry=1,flags_en=1 -> psr carry=1 next cycle; flags_en=0 op -> psr unchanged;
//    psr_we=1 psr_wdata=all-ones with flag op zero=1,others 0 -> non-APSR bits 1, APSR = in_apsr.
//  5 Flush in FULL with in_valid=1 -> next cycle out_valid=0, in_ready=1, offered op absent, psr unchanged.
//  6 rst asserted in FULL -> next cycle EMPTY, out_valid=0, psr=0; following op 0x5A retires normally.

Source files
------------

// File: rtl/alu_wb_stage.sv
// Writeback/flag-commit stage behind the ALU: 2-entry skid buffer
// toward the register-file port, plus the PSR fed back to the ALU.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   flush                    drop all buffered ops
//   in_valid/in_ready        ALU-side handshake (in_ready registered)
//   in_result/in_apsr/in_rd  ALU result, flags, destination register
//   in_wr_en/in_flags_en     regfile write / flag commit qualifiers
//   out_valid/out_ready      writeback handshake
//   out_result/out_rd        writeback data and address
//   out_wr_en                writeback enable qualifier
//   psr_we/psr_wdata         software PSR write
//   psr                      current PSR, to the ALU
module alu_wb_stage #(
  parameter int DW       = 32,
  parameter int PSRW     = 8,
  parameter int APSRW    = 3,
  parameter int APSR_MIN = 5,
  parameter int RAW      = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_result,
  input  logic [APSRW-1:0] in_apsr,
  input  logic [RAW-1:0]  in_rd,
  input  logic            in_wr_en,
  input  logic            in_flags_en,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_result,
  output logic [RAW-1:0]  out_rd,
  output logic            out_wr_en,
  input  logic            psr_we,
  input  logic [PSRW-1:0] psr_wdata,
  output logic [PSRW-1:0] psr
);

  localparam int APSR_MAX = APSR_MIN + APSRW - 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              in_ready_q;
  logic [PSRW-1:0]   psr_q, psr_d;

  logic [DW-1:0]     main_res_q, skid_res_q;
  logic [RAW-1:0]    main_rd_q, skid_rd_q;
  logic              main_we_q, skid_we_q;

  logic accept, retire;
  logic ld_main_in, ld_main_skid, ld_skid;

  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready_q & ~flush;
  assign retire    = out_valid & out_ready;

  always_comb begin
    state_d      = state_q;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            ld_main_in = 1'b1;
            state_d    = ONE;
          end
        end
        ONE: begin
          if (accept && retire) begin
            ld_main_in = 1'b1;
          end else if (accept) begin
            ld_skid = 1'b1;
            state_d = FULL;
          end else if (retire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (retire) begin
            ld_main_skid = 1'b1;
            state_d      = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Flags commit at accept so the very next ALU op sees them;
  // the flag field wins over a same-cycle software write.
  always_comb begin
    psr_d = psr_q;
    if (psr_we) psr_d = psr_wdata;
    if (accept && in_flags_en) psr_d[APSR_MAX:APSR_MIN] = in_apsr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      psr_q      <= '0;
      main_res_q <= '0;
      main_rd_q  <= '0;
      main_we_q  <= 1'b0;
      skid_res_q <= '0;
      skid_rd_q  <= '0;
      skid_we_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
      psr_q      <= psr_d;
      if (ld_main_in) begin
        main_res_q <= in_result;
        main_rd_q  <= in_rd;
        main_we_q  <= in_wr_en;
      end else if (ld_main_skid) begin
        main_res_q <= skid_res_q;
        main_rd_q  <= skid_rd_q;
        main_we_q  <= skid_we_q;
      end
      if (ld_skid) begin
        skid_res_q <= in_result;
        skid_rd_q  <= in_rd;
        skid_we_q  <= in_wr_en;
      end
    end
  end

  assign in_ready   = in_ready_q;
  assign out_result = main_res_q;
  assign out_rd     = main_rd_q;
  assign out_wr_en  = main_we_q;
  assign psr        = psr_q;

endmodule

// File: tb/tb_alu_wb_stage.sv
// Directed-vector bench for alu_wb_stage.
// PSR is 8 bits with flags {carry,zero,neg} in bits [7:5].
module tb_alu_wb_stage;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        in_valid, in_ready;
  logic [31:0] in_result;
  logic [2:0]  in_apsr;
  logic [2:0]  in_rd;
  logic        in_wr_en, in_flags_en;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [2:0]  out_rd;
  logic        out_wr_en;
  logic        psr_we;
  logic [7:0]  psr_wdata;
  logic [7:0]  psr;

  int n_vec = 0;
  int n_err = 0;

  alu_wb_stage #(
    .DW(32), .PSRW(8), .APSRW(3), .APSR_MIN(5), .RAW(3)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_apsr(in_apsr), .in_rd(in_rd),
    .in_wr_en(in_wr_en), .in_flags_en(in_flags_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_wr_en(out_wr_en),
    .psr_we(psr_we), .psr_wdata(psr_wdata), .psr(psr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [31:0] res,
                       input logic fe, input logic [2:0] apsr);
    in_valid    = v;
    in_result   = res;
    in_rd       = res[2:0];
    in_wr_en    = 1'b1;
    in_flags_en = fe;
    in_apsr     = apsr;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    psr_we = 1'b0; psr_wdata = 8'h00;
    offer(1'b1, 32'hEE, 1'b1, 3'b111);

    // 1 reset held two cycles with input offered
    step(); step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_psr", 32'(psr), 32'h00);
    check("rst_out_result", out_result, 32'h0);
    rst = 1'b0;
    offer(1'b0, 32'h0, 1'b0, 3'b000);
    step();
    check("post_rst_out_valid", 32'(out_valid), 32'd0);

    // 2 stream at full throughput
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      offer(1'b1, 32'(i), 1'b0, 3'b000);
      step();
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_result", out_result, 32'(i));
      check("stream_rd", 32'(out_rd), 32'(i % 8));
      check("stream_ready", 32'(in_ready), 32'd1);
    end
    offer(1'b0, 32'h0, 1'b0, 3'b000);
    step();
    check("stream_drain_valid", 32'(out_valid), 32'd0);
    check("stream_hold_result", out_result, 32'h8);

    // 3 backpressure fills main then skid
    out_ready = 1'b0;
    offer(1'b1, 32'h11, 1'b0, 3'b000);
    step();
    check("bp_out_11", out_result, 32'h11);
    check("bp_ready_one", 32'(in_ready), 32'd1);
    offer(1'b1, 32'h22, 1'b0, 3'b000);
    step();
    check("bp_full_ready", 32'(in_ready), 32'd0);
    check("bp_stable_11", out_result, 32'h11);
    offer(1'b1, 32'h33, 1'b0, 3'b000);
    step();
    check("bp_hold_ready", 32'(in_ready), 32'd0);
    check("bp_hold_11", out_result, 32'h11);
    check("bp_hold_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    step();
    check("bp_ret_22", out_result, 32'h22);
    check("bp_ret_ready", 32'(in_ready), 32'd1);
    step();
    check("bp_ret_33", out_result, 32'h33);
    check("bp_ret_33_valid", 32'(out_valid), 32'd1);
    offer(1'b0, 32'h0, 1'b0, 3'b000);
    step();
    check("bp_empty", 32'(out_valid), 32'd0);

    // 4 flag commit at accept
    offer(1'b1, 32'h40, 1'b1, 3'b100);
    step();
    check("flag_carry", 32'(psr), 32'h80);
    offer(1'b1, 32'h41, 1'b0, 3'b011);
    step();
    check("flag_noen", 32'(psr), 32'h80);
    offer(1'b1, 32'h42, 1'b1, 3'b010);
    psr_we = 1'b1; psr_wdata = 8'hFF;
    step();
    check("flag_and_swr", 32'(psr), 32'h5F);
    psr_we = 1'b0;
    in_wr_en = 1'b0;
    offer(1'b0, 32'h0, 1'b0, 3'b000);
    step();
    check("flag_drain", 32'(out_valid), 32'd0);

    // flag-only op still retires through the handshake
    offer(1'b1, 32'h43, 1'b0, 3'b000);
    in_wr_en = 1'b0;
    step();
    check("flagonly_valid", 32'(out_valid), 32'd1);
    check("flagonly_we", 32'(out_wr_en), 32'd0);
    offer(1'b0, 32'h0, 1'b0, 3'b000);
    step();
    check("flagonly_retired", 32'(out_valid), 32'd0);

    // 5 flush in FULL with an op offered
    out_ready = 1'b0;
    offer(1'b1, 32'h71, 1'b0, 3'b000);
    step();
    offer(1'b1, 32'h72, 1'b0, 3'b000);
    step();
    check("fl_full", 32'(in_ready), 32'd0);
    offer(1'b1, 32'h73, 1'b1, 3'b111);
    flush = 1'b1;
    step();
    check("fl_valid", 32'(out_valid), 32'd0);
    check("fl_ready", 32'(in_ready), 32'd1);
    check("fl_psr", 32'(psr), 32'h5F);
    flush = 1'b0;
    out_ready = 1'b1;
    offer(1'b0, 32'h0, 1'b0, 3'b000);
    step();
    check("fl_absent", 32'(out_valid), 32'd0);

    // flush with acceptable op: no flag commit, psr_we applies
    offer(1'b1, 32'h74, 1'b1, 3'b111);
    flush = 1'b1; psr_we = 1'b1; psr_wdata = 8'h0C;
    step();
    check("fl2_valid", 32'(out_valid), 32'd0);
    check("fl2_psr", 32'(psr), 32'h0C);
    flush = 1'b0; psr_we = 1'b0;

    // 6 reset in FULL
    out_ready = 1'b0;
    offer(1'b1, 32'h81, 1'b1, 3'b001);
    step();
    check("rf_psr_commit", 32'(psr), 32'h2C);
    offer(1'b1, 32'h82, 1'b0, 3'b000);
    step();
    check("rf_full", 32'(in_ready), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rf_valid", 32'(out_valid), 32'd0);
    check("rf_ready", 32'(in_ready), 32'd1);
    check("rf_psr", 32'(psr), 32'h00);
    out_ready = 1'b1;
    offer(1'b1, 32'h5A, 1'b0, 3'b000);
    step();
    check("rf_5a_valid", 32'(out_valid), 32'd1);
    check("rf_5a", out_result, 32'h5A);
    offer(1'b0, 32'h0, 1'b0, 3'b000);
    step();
    check("rf_5a_retired", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
